// File: rtl/spm_pkg.sv
// Shared types and default parameters for the strobe period meter.
package spm_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MEASURE = 2'd1,
    S_LOCKED  = 2'd2
  } spm_state_t;

  localparam int SPM_CNT_W       = 32;
  localparam int SPM_TIMEOUT_CYC = 1023;
  localparam int SPM_LOCK_CNT    = 2;

endpackage

// File: rtl/spm_lock_tracker.sv
// Remembers the previous measurement and counts consecutive repeats of it.
// same_o/lock_hit_o describe the measurement presented this cycle; state updates on meas_i, clr_i wins.
module spm_lock_tracker
  import spm_pkg::*;
#(
  parameter int CNT_W    = SPM_CNT_W,
  parameter int LOCK_CNT = SPM_LOCK_CNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             meas_i,
  input  logic [CNT_W-1:0] val_i,
  input  logic             clr_i,
  output logic             same_o,
  output logic             lock_hit_o
);

  localparam int             MW       = $clog2(LOCK_CNT + 1) + 1;
  localparam logic [MW-1:0]  LOCK_VAL = MW'(LOCK_CNT);

  logic [CNT_W-1:0] prev_q, prev_d;
  logic             prev_vld_q, prev_vld_d;
  logic [MW-1:0]    match_q, match_d, match_nxt;

  // A cleared tracker has no previous value, so a stale divisor never matches.
  assign same_o = prev_vld_q && (val_i == prev_q);

  always_comb begin
    if (!same_o) begin
      match_nxt = MW'(1);
    end else if (match_q >= LOCK_VAL) begin
      match_nxt = match_q;
    end else begin
      match_nxt = match_q + MW'(1);
    end
  end

  assign lock_hit_o = (match_nxt >= LOCK_VAL);

  always_comb begin
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    match_d    = match_q;
    if (clr_i) begin
      prev_vld_d = 1'b0;
      match_d    = '0;
    end else if (meas_i) begin
      prev_d     = val_i;
      prev_vld_d = 1'b1;
      match_d    = match_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      match_q    <= '0;
    end else begin
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      match_q    <= match_d;
    end
  end

endmodule

// File: rtl/strobe_period_meter.sv
// Measures the cycle gap between strobe events, reports lock and strobe loss; all outputs 1 cycle after the event.
// No backpressure. Define STROBE_PERIOD_METER_STATS_EN to keep running min/max divisor.
module strobe_period_meter
  import spm_pkg::*;
#(
  parameter int CNT_W       = SPM_CNT_W,
  parameter int TIMEOUT_CYC = SPM_TIMEOUT_CYC,
  parameter int LOCK_CNT    = SPM_LOCK_CNT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             strobe_in,
  output logic [CNT_W-1:0] div_out,
  output logic             div_valid,
  output logic             locked,
  output logic             timeout,
  output logic [CNT_W-1:0] div_min,
  output logic [CNT_W-1:0] div_max
);

  localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);

  spm_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic             div_vld_q, div_vld_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;
  logic             armed, meas, to_hit, same, lock_hit;

  assign armed  = (state_q != S_IDLE);
  assign meas   = armed && strobe_in;
  // An event on the timeout cycle is a measurement, so to_hit requires a quiet cycle.
  assign to_hit = armed && !strobe_in && (cnt_q == TO_VAL);

  spm_lock_tracker #(
    .CNT_W    (CNT_W),
    .LOCK_CNT (LOCK_CNT)
  ) u_lock (
    .clk        (clk),
    .reset      (reset),
    .meas_i     (meas),
    .val_i      (cnt_q),
    .clr_i      (to_hit),
    .same_o     (same),
    .lock_hit_o (lock_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (strobe_in) state_d = S_MEASURE;
      end
      S_MEASURE: begin
        if (meas && lock_hit) state_d = S_LOCKED;
        else if (to_hit)      state_d = S_IDLE;
      end
      S_LOCKED: begin
        if (meas && !same) state_d = S_MEASURE;
        else if (to_hit)   state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (!armed || strobe_in || to_hit) begin
      cnt_d = '0;
    end else if (cnt_q != TO_VAL) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    div_d     = meas ? cnt_q : div_q;
    div_vld_d = meas;
    timeout_d = to_hit;
    locked_d  = (state_d == S_LOCKED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      div_q     <= '0;
      div_vld_q <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      div_vld_q <= div_vld_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign div_out   = div_q;
  assign div_valid = div_vld_q;
  assign locked    = locked_q;
  assign timeout   = timeout_q;

`ifdef STROBE_PERIOD_METER_STATS_EN
  logic [CNT_W-1:0] min_q, min_d, max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (meas) begin
      if (cnt_q < min_q) min_d = cnt_q;
      if (cnt_q > max_q) max_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign div_min = min_q;
  assign div_max = max_q;
`else
  assign div_min = '0;
  assign div_max = '0;
`endif

endmodule

// File: tb/tb_strobe_period_meter.sv
// Scenario bench for strobe_period_meter: per-cycle stimulus tables with an expected-divisor scoreboard.
module tb_strobe_period_meter;

  localparam int CNT_W = 32;
  localparam int TO    = 20;
  localparam int LK    = 2;

`ifdef STROBE_PERIOD_METER_STATS_EN
  localparam logic [CNT_W-1:0] RST_MIN  = '1;
  localparam logic [CNT_W-1:0] STAT_MIN = 32'd2;
  localparam logic [CNT_W-1:0] STAT_MAX = 32'd8;
`else
  localparam logic [CNT_W-1:0] RST_MIN  = '0;
  localparam logic [CNT_W-1:0] STAT_MIN = '0;
  localparam logic [CNT_W-1:0] STAT_MAX = '0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             strobe_in;
  logic [CNT_W-1:0] div_out, div_min, div_max;
  logic             div_valid, locked, timeout;

  always #5 clk = ~clk;

  strobe_period_meter #(
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TO),
    .LOCK_CNT    (LK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .strobe_in (strobe_in),
    .div_out   (div_out),
    .div_valid (div_valid),
    .locked    (locked),
    .timeout   (timeout),
    .div_min   (div_min),
    .div_max   (div_max)
  );

  // dv: expected divisor (-1 = no div_valid); lk: expected locked (-1 = don't care).
  typedef struct {
    logic s;
    int   dv;
    int   lk;
    logic to;
  } cyc_t;

  cyc_t pat_q[$];
  int   sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void add(input logic s, input int dv, input int lk, input logic to);
    cyc_t c;
    c.s  = s;
    c.dv = dv;
    c.lk = lk;
    c.to = to;
    pat_q.push_back(c);
  endfunction

  function automatic void gap(input int n, input int lk);
    for (int k = 0; k < n; k++) add(1'b0, -1, lk, 1'b0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    strobe_in = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    pat_q.delete();
    sb_q.delete();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    strobe_in = 1'b0;
    repeat (3) tick();
    n_chk++; if (div_out !== '0)     begin n_fail++; $display("FAIL reset div_out: got %0d want 0", div_out); end
    n_chk++; if (div_valid !== 1'b0) begin n_fail++; $display("FAIL reset div_valid: got %b want 0", div_valid); end
    n_chk++; if (locked !== 1'b0)    begin n_fail++; $display("FAIL reset locked: got %b want 0", locked); end
    n_chk++; if (timeout !== 1'b0)   begin n_fail++; $display("FAIL reset timeout: got %b want 0", timeout); end
    n_chk++; if (div_min !== RST_MIN) begin n_fail++; $display("FAIL reset div_min: got %h want %h", div_min, RST_MIN); end
    n_chk++; if (div_max !== '0)     begin n_fail++; $display("FAIL reset div_max: got %h want 0", div_max); end
    reset = 1'b0;
    tick();
    n_chk++; if (div_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release div_valid: got %b want 0", div_valid); end
  endtask

  task automatic test_period5();
    int exp;
    do_reset();
    for (int e = 1; e <= 4; e++) begin
      add(1'b1, (e > 1) ? 4 : -1, (e >= 3) ? 1 : 0, 1'b0);
      gap(4, (e >= 3) ? 1 : 0);
    end
    foreach (pat_q[i]) begin
      strobe_in = pat_q[i].s;
      if (pat_q[i].dv >= 0) sb_q.push_back(pat_q[i].dv);
      tick();
      n_chk++;
      if (pat_q[i].dv >= 0) begin
        exp = sb_q.pop_front();
        if (div_valid !== 1'b1 || div_out !== CNT_W'(exp)) begin
          n_fail++; $display("FAIL period5 div cyc %0d: valid=%b div_out=%0d, want 1/%0d", i, div_valid, div_out, exp);
        end
      end else if (div_valid !== 1'b0) begin
        n_fail++; $display("FAIL period5 div_valid cyc %0d: got 1 want 0", i);
      end
      if (pat_q[i].lk >= 0) begin
        n_chk++;
        if (locked !== (pat_q[i].lk == 1)) begin n_fail++; $display("FAIL period5 locked cyc %0d: got %b want %0d", i, locked, pat_q[i].lk); end
      end
      n_chk++;
      if (timeout !== pat_q[i].to) begin n_fail++; $display("FAIL period5 timeout cyc %0d: got %b want %b", i, timeout, pat_q[i].to); end
    end
    strobe_in = 1'b0;
  endtask

  task automatic test_constant_high();
    int exp;
    do_reset();
    for (int c = 1; c <= 6; c++) add(1'b1, (c > 1) ? 0 : -1, (c >= 3) ? 1 : 0, 1'b0);
    gap(2, 1);
    foreach (pat_q[i]) begin
      strobe_in = pat_q[i].s;
      if (pat_q[i].dv >= 0) sb_q.push_back(pat_q[i].dv);
      tick();
      n_chk++;
      if (pat_q[i].dv >= 0) begin
        exp = sb_q.pop_front();
        if (div_valid !== 1'b1 || div_out !== CNT_W'(exp)) begin
          n_fail++; $display("FAIL const_high div cyc %0d: valid=%b div_out=%0d, want 1/%0d", i, div_valid, div_out, exp);
        end
      end else if (div_valid !== 1'b0) begin
        n_fail++; $display("FAIL const_high div_valid cyc %0d: got 1 want 0", i);
      end
      if (pat_q[i].lk >= 0) begin
        n_chk++;
        if (locked !== (pat_q[i].lk == 1)) begin n_fail++; $display("FAIL const_high locked cyc %0d: got %b want %0d", i, locked, pat_q[i].lk); end
      end
      n_chk++;
      if (timeout !== pat_q[i].to) begin n_fail++; $display("FAIL const_high timeout cyc %0d: got %b want %b", i, timeout, pat_q[i].to); end
    end
    strobe_in = 1'b0;
  endtask

  task automatic test_period_switch();
    int exp;
    do_reset();
    for (int e = 1; e <= 3; e++) begin
      add(1'b1, (e > 1) ? 4 : -1, (e >= 3) ? 1 : 0, 1'b0);
      if (e < 3) gap(4, 0);
    end
    gap(7, 1);
    add(1'b1, 7, 0, 1'b0);
    gap(7, 0);
    add(1'b1, 7, 1, 1'b0);
    gap(2, 1);
    foreach (pat_q[i]) begin
      strobe_in = pat_q[i].s;
      if (pat_q[i].dv >= 0) sb_q.push_back(pat_q[i].dv);
      tick();
      n_chk++;
      if (pat_q[i].dv >= 0) begin
        exp = sb_q.pop_front();
        if (div_valid !== 1'b1 || div_out !== CNT_W'(exp)) begin
          n_fail++; $display("FAIL switch div cyc %0d: valid=%b div_out=%0d, want 1/%0d", i, div_valid, div_out, exp);
        end
      end else if (div_valid !== 1'b0) begin
        n_fail++; $display("FAIL switch div_valid cyc %0d: got 1 want 0", i);
      end
      if (pat_q[i].lk >= 0) begin
        n_chk++;
        if (locked !== (pat_q[i].lk == 1)) begin n_fail++; $display("FAIL switch locked cyc %0d: got %b want %0d", i, locked, pat_q[i].lk); end
      end
      n_chk++;
      if (timeout !== pat_q[i].to) begin n_fail++; $display("FAIL switch timeout cyc %0d: got %b want %b", i, timeout, pat_q[i].to); end
    end
    strobe_in = 1'b0;
  endtask

  task automatic test_timeout();
    int exp;
    do_reset();
    for (int e = 1; e <= 3; e++) begin
      add(1'b1, (e > 1) ? 4 : -1, (e >= 3) ? 1 : 0, 1'b0);
      if (e < 3) gap(4, 0);
    end
    for (int k = 1; k <= 25; k++) add(1'b0, -1, (k < 21) ? 1 : 0, k == 21);
    // Re-arm: no div_valid on the first event, and a repeat of the stale 4 must not count as a match.
    add(1'b1, -1, 0, 1'b0);
    gap(4, 0);
    add(1'b1, 4, 0, 1'b0);
    // Event landing exactly on the timeout cycle is a measurement of TO.
    gap(TO, 0);
    add(1'b1, TO, 0, 1'b0);
    gap(TO, 0);
    add(1'b1, TO, 1, 1'b0);
    for (int k = 1; k <= 21; k++) add(1'b0, -1, (k < 21) ? 1 : 0, k == 21);
    foreach (pat_q[i]) begin
      strobe_in = pat_q[i].s;
      if (pat_q[i].dv >= 0) sb_q.push_back(pat_q[i].dv);
      tick();
      n_chk++;
      if (pat_q[i].dv >= 0) begin
        exp = sb_q.pop_front();
        if (div_valid !== 1'b1 || div_out !== CNT_W'(exp)) begin
          n_fail++; $display("FAIL timeout div cyc %0d: valid=%b div_out=%0d, want 1/%0d", i, div_valid, div_out, exp);
        end
      end else if (div_valid !== 1'b0) begin
        n_fail++; $display("FAIL timeout div_valid cyc %0d: got 1 want 0", i);
      end
      if (pat_q[i].lk >= 0) begin
        n_chk++;
        if (locked !== (pat_q[i].lk == 1)) begin n_fail++; $display("FAIL timeout locked cyc %0d: got %b want %0d", i, locked, pat_q[i].lk); end
      end
      n_chk++;
      if (timeout !== pat_q[i].to) begin n_fail++; $display("FAIL timeout pulse cyc %0d: got %b want %b", i, timeout, pat_q[i].to); end
    end
    strobe_in = 1'b0;
    n_chk++;
    if (div_out !== CNT_W'(TO)) begin n_fail++; $display("FAIL timeout div_hold: got %0d want %0d", div_out, TO); end
  endtask

  task automatic test_reset_mid();
    int exp;
    do_reset();
    for (int e = 1; e <= 3; e++) begin
      add(1'b1, (e > 1) ? 4 : -1, (e >= 3) ? 1 : 0, 1'b0);
      if (e < 3) gap(4, 0);
    end
    gap(3, 1);
    foreach (pat_q[i]) begin
      strobe_in = pat_q[i].s;
      if (pat_q[i].dv >= 0) sb_q.push_back(pat_q[i].dv);
      tick();
      n_chk++;
      if (pat_q[i].dv >= 0) begin
        exp = sb_q.pop_front();
        if (div_valid !== 1'b1 || div_out !== CNT_W'(exp)) begin
          n_fail++; $display("FAIL rst_mid_pre div cyc %0d: valid=%b div_out=%0d, want 1/%0d", i, div_valid, div_out, exp);
        end
      end else if (div_valid !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_pre div_valid cyc %0d: got 1 want 0", i);
      end
      if (pat_q[i].lk >= 0) begin
        n_chk++;
        if (locked !== (pat_q[i].lk == 1)) begin n_fail++; $display("FAIL rst_mid_pre locked cyc %0d: got %b want %0d", i, locked, pat_q[i].lk); end
      end
    end
    // Assert reset between clock edges; outputs must clear without waiting for an edge.
    reset = 1'b1;
    #2;
    n_chk++; if (div_out !== '0)      begin n_fail++; $display("FAIL rst_mid div_out: got %0d want 0", div_out); end
    n_chk++; if (locked !== 1'b0)     begin n_fail++; $display("FAIL rst_mid locked: got %b want 0", locked); end
    n_chk++; if (div_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_mid div_valid: got %b want 0", div_valid); end
    n_chk++; if (div_min !== RST_MIN) begin n_fail++; $display("FAIL rst_mid div_min: got %h want %h", div_min, RST_MIN); end
    n_chk++; if (div_max !== '0)      begin n_fail++; $display("FAIL rst_mid div_max: got %h want 0", div_max); end
    tick();
    reset = 1'b0;
    tick();
    pat_q.delete();
    sb_q.delete();
    add(1'b1, -1, 0, 1'b0);
    gap(4, 0);
    add(1'b1, 4, 0, 1'b0);
    gap(2, 0);
    foreach (pat_q[i]) begin
      strobe_in = pat_q[i].s;
      if (pat_q[i].dv >= 0) sb_q.push_back(pat_q[i].dv);
      tick();
      n_chk++;
      if (pat_q[i].dv >= 0) begin
        exp = sb_q.pop_front();
        if (div_valid !== 1'b1 || div_out !== CNT_W'(exp)) begin
          n_fail++; $display("FAIL rst_mid_post div cyc %0d: valid=%b div_out=%0d, want 1/%0d", i, div_valid, div_out, exp);
        end
      end else if (div_valid !== 1'b0) begin
        n_fail++; $display("FAIL rst_mid_post div_valid cyc %0d: got 1 want 0", i);
      end
    end
    strobe_in = 1'b0;
  endtask

  task automatic test_stats();
    int exp;
    do_reset();
    add(1'b1, -1, -1, 1'b0);
    gap(4, -1);
    add(1'b1, 4, -1, 1'b0);
    gap(2, -1);
    add(1'b1, 2, -1, 1'b0);
    gap(8, -1);
    add(1'b1, 8, -1, 1'b0);
    gap(1, -1);
    foreach (pat_q[i]) begin
      strobe_in = pat_q[i].s;
      if (pat_q[i].dv >= 0) sb_q.push_back(pat_q[i].dv);
      tick();
      n_chk++;
      if (pat_q[i].dv >= 0) begin
        exp = sb_q.pop_front();
        if (div_valid !== 1'b1 || div_out !== CNT_W'(exp)) begin
          n_fail++; $display("FAIL stats div cyc %0d: valid=%b div_out=%0d, want 1/%0d", i, div_valid, div_out, exp);
        end
      end else if (div_valid !== 1'b0) begin
        n_fail++; $display("FAIL stats div_valid cyc %0d: got 1 want 0", i);
      end
    end
    strobe_in = 1'b0;
    n_chk++; if (div_min !== STAT_MIN) begin n_fail++; $display("FAIL stats div_min: got %0d want %0d", div_min, STAT_MIN); end
    n_chk++; if (div_max !== STAT_MAX) begin n_fail++; $display("FAIL stats div_max: got %0d want %0d", div_max, STAT_MAX); end
    // Let the strobe time out; the statistics must survive it.
    repeat (TO + 5) tick();
    n_chk++; if (div_min !== STAT_MIN) begin n_fail++; $display("FAIL stats_after_to div_min: got %0d want %0d", div_min, STAT_MIN); end
    n_chk++; if (div_max !== STAT_MAX) begin n_fail++; $display("FAIL stats_after_to div_max: got %0d want %0d", div_max, STAT_MAX); end
  endtask

  initial begin
    reset     = 1'b1;
    strobe_in = 1'b0;
    test_reset();
    test_period5();
    test_constant_high();
    test_period_switch();
    test_timeout();
    test_reset_mid();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/strobe_period_meter.md
# strobe_period_meter

Recovers the divide setting of a periodic single-cycle strobe, such as the tick produced by our clock divider, by counting `clk` cycles between strobe events. Reports the measured divisor, flags when the strobe has settled to a stable period, and detects loss of the strobe. Sits on the consumer side of divided-clock ticks in the Fourier-transformation datapath for self-check and rate monitoring.

## Interface
- `CNT_W`, 32: width of the cycle counter and the divisor outputs.
- `TIMEOUT_CYC`, 1023: gap count that declares the strobe lost; must be below 2^CNT_W − 1.
- `LOCK_CNT`, 2: number of consecutive identical measurements needed to lock; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `strobe_in`  in  1  event input, synchronous to `clk`; every cycle it is high counts as one event.
- `div_out`  out  CNT_W  last measured divisor (gap cycles between events).
- `div_valid`  out  1  one-cycle pulse when `div_out` updates.
- `locked`  out  1  high while the period is stable.
- `timeout`  out  1  one-cycle pulse when the strobe is declared lost.
- `div_min`, `div_max`  out  CNT_W  running min/max divisor (see Configuration).

## Operation
- Reset: state S_IDLE, counter 0, match count 0, `div_out`=0, `div_valid`=0, `locked`=0, `timeout`=0, `div_min`=all-ones, `div_max`=0.
- Counter: cleared on every event; +1 on each non-event cycle; saturates at TIMEOUT_CYC. Counter value at an event = divisor (strobe every N cycles → N−1).
- S_IDLE: counter held at 0; on event → S_MEASURE, match count 0, no `div_valid`.
- S_MEASURE: on event, `div_out`←counter and `div_valid` pulses. If the value equals the previous `div_out` and a previous measurement exists, match count +1; otherwise match count ← 1. When match count reaches LOCK_CNT → S_LOCKED, `locked`=1.
- S_LOCKED: on event, `div_out` and `div_valid` as above. If the value differs → S_MEASURE, `locked`=0, match count ← 1.
- Timeout: from S_MEASURE or S_LOCKED, a non-event cycle with counter == TIMEOUT_CYC → S_IDLE, `timeout` pulse, `locked`=0, match count 0; `div_out` holds.
- An event in the same cycle as the timeout condition counts as an event. Timeout does not fire.
- `strobe_in` held high: each cycle is an event with divisor 0.
- The first measurement after S_IDLE never counts as a match with a stale `div_out`.

## Timing
- All outputs registered. `div_valid`, `div_out`, and `locked` update in the cycle after the sampling edge that sees the event. Latency is 1 clock.
- `timeout` asserts the cycle after the edge where the counter is at TIMEOUT_CYC with no event, i.e. TIMEOUT_CYC+1 non-event cycles after the last event.
- Asserting `reset` mid-measurement clears all state immediately and asynchronously. The first event after release enters S_MEASURE.

## Configuration
- `STROBE_PERIOD_METER_STATS_EN` defined: on each `div_valid`, `div_min`←min(`div_min`, value) and `div_max`←max(`div_max`, value). Timeout does not clear them; only reset does.
- Not defined: stats logic is absent. `div_min` and `div_max` are constant 0.

## Structure
- Package `spm_pkg`:
  - state enum typedef `spm_state_t` (S_IDLE, S_MEASURE, S_LOCKED);
  - default constants `SPM_CNT_W`, `SPM_TIMEOUT_CYC`, `SPM_LOCK_CNT`.
- One sub-module, `spm_lock_tracker`: holds the previous value, match count and lock decision; it is fed a measurement strobe plus value and a clear.

## Test plan
- Strobe every 5 cycles (divider max=4) → `div_valid` every 5 cycles with `div_out`=4; `locked`=1 one cycle after the 3rd event (LOCK_CNT=2).
- `strobe_in` constantly high → `div_out`=0 with `div_valid` every cycle; `locked`=1 from the 3rd cycle.
- Locked at period 5, then switch to period 8 → next `div_out`=7, `locked` drops the same cycle; relocks on the following matching measurement.
- Strobe stops with TIMEOUT_CYC=20 → `timeout` pulses exactly 21 non-event cycles after the last event; `locked`=0; the next event produces no `div_valid`.
- `reset` asserted 3 cycles into a measurement → all outputs 0 immediately; after release, first `div_valid` only on the second event.
- With `STROBE_PERIOD_METER_STATS_EN`, periods 5, 3, 9 → `div_min`=2, `div_max`=8; without the macro, both stay 0.
